// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// State encodings are pinned so the FSM can be read directly on a debug bus.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc/adel, priority flush > stall > load.
// One-cycle register; a stall holds every field, no load with no stall inserts a bubble.
module fetch_stage_if_id_reg (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_adel,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_adel
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_adel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
            r_adel  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_instr <= i_instr;
                r_pc    <= i_pc;
                r_adel  <= i_adel;
            end else begin
                // instr/pc keep their last values across a bubble
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_adel  = r_adel;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC generation and one-outstanding SRAM-like fetch, feeding the IF/ID register.
// valid_d one cycle after data_ok; stall_d parks a returned word in a hold buffer, no new request meanwhile.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_d,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        adel_d
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc_f, w_pc_nxt;
    logic         r_pend, w_pend_nxt;
    logic [31:0]  r_pend_pc, w_pend_pc_nxt;
    logic         r_discard, w_discard_nxt;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_req_pc;

    logic         w_aligned, w_accept, w_redirect;
    logic         w_hold_we, w_load, w_load_adel;
    logic [31:0]  w_load_instr, w_load_pc;

    assign w_aligned  = (r_pc_f[1:0] == 2'b00);
    assign w_accept   = w_aligned & inst_addr_ok;
    assign w_redirect = redirect_en & ~stall_d;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc_f;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_discard_nxt = r_discard;
        w_hold_we     = 1'b0;
        w_load        = 1'b0;
        w_load_adel   = 1'b0;
        w_load_instr  = 32'd0;
        w_load_pc     = r_req_pc;

        case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    // A redirect arriving with the delay slot's accept goes straight to the target
                    w_state_nxt = S_WAIT;
                    w_pend_nxt  = 1'b0;
                    if (w_redirect)  w_pc_nxt = redirect_pc;
                    else if (r_pend) w_pc_nxt = r_pend_pc;
                    else             w_pc_nxt = pc_plus4(r_pc_f);
                end else begin
                    if (w_redirect) begin
                        w_pend_nxt    = 1'b1;
                        w_pend_pc_nxt = redirect_pc;
                    end
                    if (!w_aligned && !stall_d) begin
                        w_load      = 1'b1;
                        w_load_adel = 1'b1;
                        w_load_pc   = r_pc_f;
                        w_pc_nxt    = pc_plus4(r_pc_f);
                    end
                end
            end
            S_WAIT: begin
                if (w_redirect) w_pc_nxt = redirect_pc;
                if (inst_data_ok) begin
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else if (!stall_d) begin
                        w_load       = 1'b1;
                        w_load_instr = inst_rdata;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_hold_we   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redirect) w_pc_nxt = redirect_pc;
                if (!stall_d) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold_instr;
                    w_state_nxt  = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase

        if (flush) begin
            w_pc_nxt   = flush_pc;
            w_pend_nxt = 1'b0;
            w_hold_we  = 1'b0;
            w_load     = 1'b0;
            case (r_state)
                S_REQ: begin
                    w_state_nxt   = w_accept ? S_WAIT : S_REQ;
                    w_discard_nxt = w_accept;
                end
                S_WAIT: begin
                    w_state_nxt   = inst_data_ok ? S_REQ : S_WAIT;
                    w_discard_nxt = ~inst_data_ok;
                end
                default: begin
                    w_state_nxt   = S_REQ;
                    w_discard_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_REQ;
            r_pc_f       <= RESET_PC;
            r_pend       <= 1'b0;
            r_pend_pc    <= 32'd0;
            r_discard    <= 1'b0;
            r_hold_instr <= 32'd0;
            r_req_pc     <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc_f    <= w_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_discard <= w_discard_nxt;
            if (w_hold_we)                  r_hold_instr <= inst_rdata;
            if (r_state == S_REQ && w_accept) r_req_pc   <= r_pc_f;
        end
    end

    assign inst_req  = resetn & (r_state == S_REQ) & w_aligned;
    assign inst_addr = r_pc_f;

    fetch_stage_if_id_reg u_if_id (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (flush),
        .i_stall (stall_d),
        .i_load  (w_load),
        .i_instr (w_load_instr),
        .i_pc    (w_load_pc),
        .i_adel  (w_load_adel),
        .o_valid (valid_d),
        .o_instr (instr_d),
        .o_pc    (pc_d),
        .o_adel  (adel_d)
    );

endmodule
